// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, register-address constants and load-use compare for the pipeline sequencer
package pipe_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_MEM_WAIT, S_ERROR} state_e;
  function automatic logic lu_haz(input logic memread, input logic [REG_ADDR_W-1:0] ex_rt,
                                  input logic [REG_ADDR_W-1:0] id_rs, input logic [REG_ADDR_W-1:0] id_rt,
                                  input logic uses_rt);
    return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit saturating up-counter; inc_i adds one unless all-ones, rst_i (async, high) clears
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage sequencer; in: hazard/branch/dmem status, out: PC/IFID/IDEX control, freeze, timeout, stall/flush stats
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  pipe_freeze_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_e        state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_busy, haz, active, flush_inc, stall_inc;
  always_comb begin
    mem_busy      = dmem_req_i & ~dmem_ack_i;
    haz           = lu_haz(ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i);
    active        = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
    state_d       = state_q;
    boot_d        = boot_q;
    wait_d        = wait_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    flush_inc     = 1'b0;
    case (state_q)
      S_BOOT: begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        boot_d        = boot_q + 1'b1;
        state_d       = (boot_q == BW'(BOOT_CYCLES - 1)) ? S_RUN : S_BOOT;
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_busy) begin
          // the busy cycle that makes the count hit MEM_TIMEOUT is the last one tolerated
          pipe_freeze_o = 1'b1;
          wait_d        = wait_q + 1'b1;
          state_d       = (wait_d == WW'(MEM_TIMEOUT)) ? S_ERROR : S_MEM_WAIT;
        end else begin
          state_d = S_RUN;
          wait_d  = '0;
          if (haz) idex_bubble_o = 1'b1;
          else if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
            flush_inc    = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
      end
      default: pipe_freeze_o = 1'b1;
    endcase
  end
  assign stall_inc = active & ~pc_write_o;
  assign timeout_o = (state_q == S_ERROR);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= S_BOOT;
      boot_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(stall_inc), .cnt_o(stall_cnt_o));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(flush_inc), .cnt_o(flush_cnt_o));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random checks of two sequencer instances (wide and 2-bit stats) against a history model
module tb_pipeline_hazard_ctrl;
  localparam int BOOT = 2;
  localparam int TO   = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, branch_taken, dmem_req, dmem_ack;
  logic pc_a, ifw_a, fl_a, bb_a, fz_a, to_a, pc_b, ifw_b, fl_b, bb_b, fz_b, to_b;
  logic [15:0] st_a, fc_a;
  logic [1:0] st_b, fc_b;
  int total = 0, bad = 0;
  int m_cyc, m_run, m_stall, m_flush;
  bit m_err;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TO), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken), .dmem_req_i(dmem_req),
    .dmem_ack_i(dmem_ack), .pc_write_o(pc_a), .ifid_write_o(ifw_a), .ifid_flush_o(fl_a),
    .idex_bubble_o(bb_a), .pipe_freeze_o(fz_a), .timeout_o(to_a), .stall_cnt_o(st_a), .flush_cnt_o(fc_a));
  pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TO), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken), .dmem_req_i(dmem_req),
    .dmem_ack_i(dmem_ack), .pc_write_o(pc_b), .ifid_write_o(ifw_b), .ifid_flush_o(fl_b),
    .idex_bubble_o(bb_b), .pipe_freeze_o(fz_b), .timeout_o(to_b), .stall_cnt_o(st_b), .flush_cnt_o(fc_b));
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                        input logic uses, input logic mr, input logic br, input logic rq, input logic ak);
    id_rs = rs; id_rt = rt; ex_rt = ert; id_uses_rt = uses;
    ex_memread = mr; branch_taken = br; dmem_req = rq; dmem_ack = ak;
  endtask
  task automatic check_cycle();
    logic [5:0] e_ctl;
    logic [15:0] e_sa, e_fa;
    logic [1:0] e_sb, e_fb;
    bit boot, busy, haz, p3;
    if (rst) begin
      m_cyc = 0; m_run = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end
    boot = m_cyc < BOOT;
    busy = dmem_req && !dmem_ack;
    haz  = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    p3   = !boot && !m_err && !busy && !haz && branch_taken;
    // bit order: pc_write, ifid_write, ifid_flush, idex_bubble, freeze, timeout
    e_ctl = boot ? 6'b001100 : m_err ? 6'b000011 : busy ? 6'b000010 :
            haz ? 6'b000100 : branch_taken ? 6'b101000 : 6'b110000;
    e_sa = (m_stall > 65535) ? 16'hffff : 16'(m_stall);
    e_fa = (m_flush > 65535) ? 16'hffff : 16'(m_flush);
    e_sb = (m_stall > 3) ? 2'd3 : 2'(m_stall);
    e_fb = (m_flush > 3) ? 2'd3 : 2'(m_flush);
    total++;
    assert ({pc_a, ifw_a, fl_a, bb_a, fz_a, to_a} === e_ctl) else begin
      bad++; $error("FAIL ctl_a t=%0t got=%b exp=%b", $time, {pc_a, ifw_a, fl_a, bb_a, fz_a, to_a}, e_ctl);
    end
    total++;
    assert ({pc_b, ifw_b, fl_b, bb_b, fz_b, to_b} === e_ctl) else begin
      bad++; $error("FAIL ctl_b t=%0t got=%b exp=%b", $time, {pc_b, ifw_b, fl_b, bb_b, fz_b, to_b}, e_ctl);
    end
    total++;
    assert ({st_a, fc_a} === {e_sa, e_fa}) else begin
      bad++; $error("FAIL cnt_a t=%0t got=%0d/%0d exp=%0d/%0d", $time, st_a, fc_a, e_sa, e_fa);
    end
    total++;
    assert ({st_b, fc_b} === {e_sb, e_fb}) else begin
      bad++; $error("FAIL cnt_b t=%0t got=%0d/%0d exp=%0d/%0d", $time, st_b, fc_b, e_sb, e_fb);
    end
    if (!rst) begin
      if (boot) m_cyc++;
      else if (!m_err) begin
        if (busy) begin
          m_run++;
          if (m_run == TO) m_err = 1;
        end else m_run = 0;
        if (!e_ctl[5]) m_stall++;
        if (p3) m_flush++;
      end
    end
  endtask
  task automatic tick();
    #1 check_cycle();
    @(negedge clk);
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    set_in(5, 0, 5, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_in(1, 7, 7, 1, 1, 1, 0, 0); tick();
    set_in(1, 7, 0, 1, 0, 1, 0, 0); tick();
    total++;
    assert (fc_a === 16'd1) else begin
      bad++; $error("FAIL flush_after_branch got=%0d exp=1", fc_a);
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0); repeat (3) tick();
    dmem_ack = 1'b1; tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(3, 0, 3, 0, 1, 0, 0, 0); repeat (5) tick();
    total++;
    assert (st_b === 2'd3) else begin
      bad++; $error("FAIL stall_sat got=%0d exp=3", st_b);
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0); repeat (6) tick();
    dmem_ack = 1'b1; tick();
    total++;
    assert (to_a === 1'b1) else begin
      bad++; $error("FAIL timeout_sticky got=%b exp=1", to_a);
    end
    rst = 1'b1; tick();
    rst = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0); repeat (2) tick();
    #3 rst = 1'b1;
    tick();
    rst = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();
    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 9) == 0) begin
        dmem_req = 1'b1; dmem_ack = 1'b0;
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
